mod_sha_compress: RTL
=====================

# mod_sha_compress

SHA-256 compression engine; reads the message schedule from the W-memory and folds one 512-bit block into the running digest. It sits downstream of the W-memory: it drives the round index `I` and consumes `W[I]` from the memory's `D_OUT`. It runs 64 rounds at one round per cycle, then adds the working variables into the hash state. Multi-block messages chain through the retained digest.

## Interface
- No parameters. Constants are fixed:
  - K[0..63] is an internal ROM holding the FIPS 180-4 round constants.
  - IV is 6a09e667, bb67ae85, 3c6ef372, a54ff53a, 510e527f, 9b05688c, 1f83d9ab, 5be0cd19.
- `CLK` in 1: the single clock; rising-edge active.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: sampled in IDLE only; begins one block.
- `FIRST` in 1: sampled with `START`. 1 = seed from IV; 0 = chain from current `H_OUT`.
- `I` out 6: round index presented to the W-memory.
- `W_IN` in 32: W[I], taken from the W-memory `D_OUT`. Must be valid in the same cycle `I` is presented (combinational path through the memory).
- `BUSY` out 1: high from the cycle after `START` is accepted until `DONE`.
- `DONE` out 1: one-cycle pulse; `H_OUT` is final from this cycle on.
- `H_OUT` out 256: digest. H0 in [255:224], H7 in [31:0].

## Operation
- States: IDLE, ROUND, FINAL.
- IDLE, `START`=1: load a..h from IV (`FIRST`=1) or from H (`FIRST`=0); also load H from IV when `FIRST`=1. Set t=0, go to ROUND. `START`=0 stays in IDLE.
- ROUND: each edge performs one round using `W_IN` and K[t]:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W_IN
  - T2 = Σ0(a) + Maj(a,b,c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - t increments; after t=63 the next state is FINAL.
- FINAL: Hk ← Hk + working variable k, for k=0..7. Pulse `DONE`, return to IDLE.
- All additions are modulo 2^32; carries are discarded.
- `I` = t in ROUND; `I` = 0 in IDLE and FINAL. `I` wraps 63→0 only through the FINAL transition.
- `START` while not IDLE is ignored; no queuing.
- `FIRST` is ignored unless `START` is accepted.
- `W_IN` is ignored outside ROUND.
- `RST` in any state, including mid-round:
  - state → IDLE, t=0
  - a..h = 0, H = IV
  - `BUSY`=0, `DONE`=0, `I`=0
  - The partial block is discarded.
- Reset values: `I`=0, `BUSY`=0, `DONE`=0, `H_OUT`=IV.

## Timing
- Edge N accepts `START`. Edges N+1..N+64 execute rounds 0..63. Edge N+65 performs FINAL.
- `DONE`=1 in the cycle following edge N+65; `H_OUT` updates on that same edge.
- Latency from `START` to `DONE` is 65 cycles, without stalls.
- `BUSY` is high from edge N through edge N+65.
- A new `START` can be accepted in the cycle in which `DONE` is high, giving back-to-back blocks every 66 cycles.
- `H_OUT` is stable from `DONE` until the next FINAL or `RST`.

## Configuration
- `SHA_COMPRESS_STALL_EN` defined:
  - Adds input `W_VALID` (1 bit).
  - In ROUND, a round executes only on edges where `W_VALID`=1. Otherwise a..h, t and `I` hold.
  - `RST` still overrides.
  - Latency = 65 + number of stall cycles.
- Undefined: no `W_VALID` port; `W_IN` is treated as valid every ROUND cycle.

## Test plan
- **Reset:** assert `RST` 2 cycles → `H_OUT`=6a09e667…5be0cd19, `BUSY`=0, `DONE`=0, `I`=0.
- **"Hello world!" block:** padded W stream from the W-memory, `FIRST`=1 → `DONE` exactly 65 cycles after `START`, `H_OUT`=c0535e4be2b79ffd93291305436bf889314e4a3faec05ecffcbb7df31ad9e51a; `I` steps 0..63.
- **"abc" block:** `FIRST`=1 → ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- **Two-block chaining:**
  - Message: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq".
  - Stimulus: block 1 with `FIRST`=1, then block 2 with `FIRST`=0, `START` issued in block 1's `DONE` cycle.
  - Response: `H_OUT`=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - Ignored `START`: a `START` pulsed at round 30 of a block → no effect on the result.
- **Reset mid-operation:** `RST` at round 40 → IDLE next cycle, `H_OUT`=IV, no `DONE`. A subsequent "abc" run still gives ba7816bf…15ad.
- **`SHA_COMPRESS_STALL_EN`:** "abc" block with `W_VALID` low every 3rd cycle → same digest; `DONE` delayed by exactly the count of stalled ROUND cycles; `I` holds during stalls.

Source files
------------

// File: rtl/mod_sha_compress.sv
// mod_sha_compress: SHA-256 compression engine.
// Drives the round index I into the W-memory and takes W[I] back on W_IN in
// the same cycle. Runs 64 rounds (one per clock), then one FINAL cycle that
// adds the working variables into the retained digest H_OUT.
// Optional macro SHA_COMPRESS_STALL_EN adds a W_VALID input; rounds then only
// advance on cycles where W_VALID is high.
//
// Handshake: START is only looked at in IDLE, and FIRST only on the edge that
// accepts START. BUSY is high while a block is in flight (ROUND and FINAL).
// DONE pulses for one cycle as the engine re-enters IDLE; a new START may be
// accepted in that same cycle, and H_OUT holds until the next FINAL or RST.
module mod_sha_compress (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic         FIRST,
`ifdef SHA_COMPRESS_STALL_EN
  input  logic         W_VALID,
`endif
  input  logic [31:0]  W_IN,
  output logic [5:0]   I,
  output logic         BUSY,
  output logic         DONE,
  output logic [255:0] H_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // State register is kept as a named enum so checkers can observe it directly.
  state_t      state;
  logic [5:0]  t;
  logic [31:0] a, b, c, d, e, f, g, h;
  logic [255:0] h_q;
  logic        busy_q;
  logic        done_q;
  logic        round_en;

  logic [31:0] t1, t2;
  logic [255:0] h_sum;

`ifdef SHA_COMPRESS_STALL_EN
  assign round_en = W_VALID;
`else
  assign round_en = 1'b1;
`endif

  // Round datapath and the end-of-block digest addition.
  always_comb begin
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
           + ((e & f) ^ (~e & g)) + K_ROM[t] + W_IN;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
           + ((a & b) ^ (a & c) ^ (b & c));
    h_sum = {
      h_q[255:224] + a, h_q[223:192] + b, h_q[191:160] + c, h_q[159:128] + d,
      h_q[127:96]  + e, h_q[95:64]    + f, h_q[63:32]    + g, h_q[31:0]     + h
    };
  end

  // Control FSM with working variables, round counter and digest registers.
  // t wraps 63->0 as the last round executes, so it already reads 0 in FINAL.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      t      <= 6'd0;
      {a, b, c, d, e, f, g, h} <= '0;
      h_q    <= IV;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (FIRST) begin
              {a, b, c, d, e, f, g, h} <= IV;
              h_q <= IV;
            end else begin
              {a, b, c, d, e, f, g, h} <= h_q;
            end
            t      <= 6'd0;
            busy_q <= 1'b1;
            state  <= ROUND;
          end
        end
        ROUND: begin
          if (round_en) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            t <= t + 6'd1;
            if (t == 6'd63) begin
              state <= FINAL;
            end
          end
        end
        FINAL: begin
          h_q    <= h_sum;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          t      <= 6'd0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign I     = t;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign H_OUT = h_q;

endmodule
